// File: rtl/result_display_driver.sv
// Converts a settled X/Y result pair to BCD and scans it onto an 8-digit active-low 7-segment display.
// X occupies digits 7..4, Y occupies digits 3..0; a conversion takes 29 cycles.
module result_display_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter int STABLE_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        Valid,
  output logic        Busy,
  output logic        Overflow
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CONV_X, CONV_Y, COMMIT} state_t;

  state_t        state;
  logic [31:0]   x_q, y_q, last_x, last_y, cap_x, cap_y;
  logic [SW-1:0] stable_cnt;
  logic [RW-1:0] ref_cnt;
  logic [2:0]    idx;
  logic [29:0]   sh, sh_nxt;
  logic [3:0]    bit_cnt;
  logic [13:0]   y_cap;
  logic [15:0]   x_bcd;
  logic          ovf_cap;
  logic [31:0]   digits;
  logic          start;

  // One double-dabble step: BCD field is sh[29:14], binary field sh[13:0].
  function automatic logic [29:0] dd_step(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd5) t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  function automatic logic [13:0] sat14(input logic [31:0] v);
    return (v > 32'd9999) ? 14'd9999 : v[13:0];
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb sh_nxt = dd_step(sh);

  // Before the first commit there is no meaningful last pair, so (0,0) still converts.
  always_comb start = (stable_cnt == SW'(STABLE_CYCLES)) && (state == IDLE) &&
                      (!Valid || (x_q != last_x) || (y_q != last_y));

  always_ff @(posedge Clk) begin
    x_q <= X;
    y_q <= Y;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stable_cnt <= '0;
    end else if ((X != x_q) || (Y != y_q)) begin
      stable_cnt <= '0;
    end else if (stable_cnt != SW'(STABLE_CYCLES)) begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      sh       <= '0;
      bit_cnt  <= '0;
      y_cap    <= '0;
      x_bcd    <= '0;
      cap_x    <= '0;
      cap_y    <= '0;
      ovf_cap  <= 1'b0;
      digits   <= '0;
      last_x   <= '0;
      last_y   <= '0;
      Valid    <= 1'b0;
      Busy     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh      <= {16'd0, sat14(x_q)};
          y_cap   <= sat14(y_q);
          cap_x   <= x_q;
          cap_y   <= y_q;
          ovf_cap <= (x_q > 32'd9999) || (y_q > 32'd9999);
          bit_cnt <= '0;
          Busy    <= 1'b1;
          state   <= CONV_X;
        end
        CONV_X: begin
          bit_cnt <= bit_cnt + 1'b1;
          sh      <= sh_nxt;
          if (bit_cnt == 4'd13) begin
            x_bcd   <= sh_nxt[29:14];
            sh      <= {16'd0, y_cap};
            bit_cnt <= '0;
            state   <= CONV_Y;
          end
        end
        CONV_Y: begin
          bit_cnt <= bit_cnt + 1'b1;
          sh      <= sh_nxt;
          if (bit_cnt == 4'd13) state <= COMMIT;
        end
        COMMIT: begin
          digits   <= {x_bcd, sh[29:14]};
          Overflow <= ovf_cap;
          last_x   <= cap_x;
          last_y   <= cap_y;
          Valid    <= 1'b1;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ref_cnt <= '0;
      idx     <= '0;
      an      <= 8'hFF;
      seg     <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      if (Valid) begin
        an  <= ~(8'b1 << idx);
        seg <= decode(digits[{idx, 2'b00} +: 4]);
        dp  <= (idx != 3'd4);
      end else begin
        an  <= 8'hFF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule
